uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START_BIT = 2'b01,
    STREAMING = 2'b10,
    STOP_BIT  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized line, one-cycle valid and
// frame-error pulses, and an armed flag so a held-low line never retriggers a frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_active,
  output logic       rx_frame_err
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF     = CW'((CLKS_PER_BIT - 1) / 2);

  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          armed;
  logic          rx_sync;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_active    <= 1'b0;
      armed        <= 1'b0;
    end else begin
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // A start edge only counts once the line has been seen high.
          if (armed && !rx_sync) begin
            state     <= START_BIT;
            armed     <= 1'b0;
            rx_active <= 1'b1;
          end else if (rx_sync) begin
            armed <= 1'b1;
          end
        end
        START_BIT: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_sync) begin
              state <= STREAMING;
            end else begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STREAMING: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_sync;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP_BIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP_BIT: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            rx_active <= 1'b0;
            // A good stop bit proves the line is high, so stay armed for a back-to-back start.
            if (rx_sync) begin
              rx_byte <= shift;
              rx_dv   <= 1'b1;
              armed   <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
